// File: rtl/dip_array_ctrl.sv
// Tile sequencer for the DiP systolic array: LOAD_W -> STREAM -> FLUSH -> DRAIN per tile.
// Optional macro DIP_CTRL_ABORT_EN adds an abort input that cancels a running command.
module dip_array_ctrl #(
   parameter int N  = 4,
   parameter int TW = 8
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   input  logic [TW-1:0]        num_tiles,
   input  logic                 out_ready,
`ifdef DIP_CTRL_ABORT_EN
   input  logic                 abort,
`endif
   output logic                 busy,
   output logic                 done,
   output logic                 w_load_en,
   output logic [$clog2(N)-1:0] w_addr,
   output logic                 x_valid,
   output logic [$clog2(N)-1:0] x_addr,
   output logic                 acc_clr,
   output logic                 out_valid,
   output logic [$clog2(N)-1:0] out_row,
   output logic [TW-1:0]        tile_idx
);

   localparam int CW = $clog2(N);
   localparam logic [CW-1:0] CNT_LAST       = CW'(N - 1);
   localparam logic [CW-1:0] CNT_FLUSH_LAST = CW'(N - 2);

   typedef enum logic [2:0] {
      S_IDLE,
      S_LOAD_W,
      S_STREAM,
      S_FLUSH,
      S_DRAIN
   } state_t;

   state_t          state_q, state_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic [TW-1:0]   tile_q, tile_d;
   logic [TW-1:0]   num_q, num_d;
   logic            done_q, done_d;

   // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         tile_q  <= '0;
         num_q   <= '0;
         done_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         tile_q  <= tile_d;
         num_q   <= num_d;
         done_q  <= done_d;
      end
   end

   // NOTE: every next-state signal gets a default first so no path through the case infers a latch.
   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q + CW'(1);
      tile_d  = tile_q;
      num_d   = num_q;
      done_d  = 1'b0;

      unique case (state_q)
         S_IDLE: begin
            cnt_d = '0;
            if (start) begin
               if (num_tiles != '0) begin
                  state_d = S_LOAD_W;
                  num_d   = num_tiles;
                  tile_d  = '0;
               end else begin
                  done_d = 1'b1;
               end
            end
         end
         S_LOAD_W: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_STREAM;
               cnt_d   = '0;
            end
         end
         S_STREAM: begin
            if (cnt_q == CNT_LAST) begin
               state_d = S_FLUSH;
               cnt_d   = '0;
            end
         end
         S_FLUSH: begin
            if (cnt_q == CNT_FLUSH_LAST) begin
               state_d = S_DRAIN;
               cnt_d   = '0;
            end
         end
         S_DRAIN: begin
            // Row index only advances on an accepted output row.
            cnt_d = cnt_q;
            if (out_ready) begin
               if (cnt_q == CNT_LAST) begin
                  cnt_d = '0;
                  if (tile_q == num_q - TW'(1)) begin
                     state_d = S_IDLE;
                     tile_d  = '0;
                     done_d  = 1'b1;
                  end else begin
                     state_d = S_LOAD_W;
                     tile_d  = tile_q + TW'(1);
                  end
               end else begin
                  cnt_d = cnt_q + CW'(1);
               end
            end
         end
         default: begin
            state_d = S_IDLE;
            cnt_d   = '0;
         end
      endcase

`ifdef DIP_CTRL_ABORT_EN
      if (abort && state_q != S_IDLE) begin
         state_d = S_IDLE;
         cnt_d   = '0;
         tile_d  = '0;
         done_d  = 1'b0;
      end
`endif
   end

   // Outputs decode registered state only; out_ready never reaches them combinationally.
   assign busy      = (state_q != S_IDLE);
   assign done      = done_q;
   assign w_load_en = (state_q == S_LOAD_W);
   assign w_addr    = w_load_en ? cnt_q : '0;
   assign x_valid   = (state_q == S_STREAM);
   assign x_addr    = x_valid ? cnt_q : '0;
   assign acc_clr   = x_valid && (cnt_q == '0);
   assign out_valid = (state_q == S_DRAIN);
   assign out_row   = out_valid ? cnt_q : '0;
   assign tile_idx  = tile_q;

endmodule
